// File: rtl/tsn_sched_pkg.sv
// Shared constants, FSM encoding and slot-count helper for the gate slot scheduler.
package tsn_sched_pkg;

  localparam int unsigned TIMER_W    = 19;
  localparam int unsigned TIMER_MAX  = 499999;
  localparam int unsigned SLOT_NUM   = 16;
  localparam int unsigned GATE_W     = 8;
  localparam int unsigned SLOT_W     = 4;
  localparam int unsigned SLOT_NUM_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  // Index of the last active slot: 0 counts as one slot, oversize counts are clamped.
  function automatic logic [SLOT_W-1:0] last_slot(input logic [SLOT_NUM_W-1:0] num,
                                                  input int unsigned slots);
    logic [SLOT_W-1:0] r;
    r = '0;
    if (num == '0) begin
      r = '0;
    end else if (32'(num) > slots) begin
      r = SLOT_W'(slots - 1);
    end else begin
      r = SLOT_W'(num - 1'b1);
    end
    return r;
  endfunction

endpackage

// File: rtl/gcl_table.sv
// Gate control list storage: {slot_end, gate} per slot, with an optional shadow
// copy (GATE_SHADOW_EN) that is committed to the active list at cycle boundaries.
module gcl_table #(
  parameter int unsigned GATE_W    = tsn_sched_pkg::GATE_W,
  parameter int unsigned SLOT_NUM  = tsn_sched_pkg::SLOT_NUM,
  parameter int unsigned TIMER_MAX = tsn_sched_pkg::TIMER_MAX
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr,
  input  logic [tsn_sched_pkg::SLOT_W-1:0]   addr,
  input  logic [tsn_sched_pkg::TIMER_W-1:0]  wr_end,
  input  logic [GATE_W-1:0]                  wr_gate,
`ifdef GATE_SHADOW_EN
  input  logic                               commit,
`endif
  input  logic [tsn_sched_pkg::SLOT_W-1:0]   cur_idx,
  output logic [tsn_sched_pkg::TIMER_W-1:0]  cur_end_c,
  output logic [GATE_W-1:0]                  nxt_gate_c,
  output logic [GATE_W-1:0]                  first_gate_c
);
  import tsn_sched_pkg::*;

  localparam int unsigned IDX_W = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;

  logic [TIMER_W-1:0] act_end  [SLOT_NUM];
  logic [GATE_W-1:0]  act_gate [SLOT_NUM];

  logic              wr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [SLOT_W-1:0] nxt_idx;

  assign wr_ok   = wr && (32'(addr) < SLOT_NUM);
  assign wr_idx  = IDX_W'(addr);
  assign nxt_idx = cur_idx + SLOT_W'(1);

`ifdef GATE_SHADOW_EN
  logic [TIMER_W-1:0] sh_end_q  [SLOT_NUM];
  logic [GATE_W-1:0]  sh_gate_q [SLOT_NUM];
  logic [TIMER_W-1:0] sh_end_d  [SLOT_NUM];
  logic [GATE_W-1:0]  sh_gate_d [SLOT_NUM];

  // Shadow image including this cycle's write, so a boundary commit never drops it.
  always_comb begin
    sh_end_d  = sh_end_q;
    sh_gate_d = sh_gate_q;
    if (wr_ok) begin
      sh_end_d[wr_idx]  = wr_end;
      sh_gate_d[wr_idx] = wr_gate;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SLOT_NUM); i++) begin
        sh_end_q[i]  <= TIMER_W'(TIMER_MAX);
        sh_gate_q[i] <= '1;
        act_end[i]   <= TIMER_W'(TIMER_MAX);
        act_gate[i]  <= '1;
      end
    end else begin
      sh_end_q  <= sh_end_d;
      sh_gate_q <= sh_gate_d;
      if (commit) begin
        act_end  <= sh_end_d;
        act_gate <= sh_gate_d;
      end
    end
  end

  // The slot-0 reload happens on the same edge as the commit, so it sees the new list.
  assign first_gate_c = commit ? sh_gate_d[0] : act_gate[0];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SLOT_NUM); i++) begin
        act_end[i]  <= TIMER_W'(TIMER_MAX);
        act_gate[i] <= '1;
      end
    end else if (wr_ok) begin
      act_end[wr_idx]  <= wr_end;
      act_gate[wr_idx] <= wr_gate;
    end
  end

  assign first_gate_c = act_gate[0];
`endif

  assign cur_end_c  = (32'(cur_idx) < SLOT_NUM) ? act_end[IDX_W'(cur_idx)] : TIMER_W'(TIMER_MAX);
  assign nxt_gate_c = (32'(nxt_idx) < SLOT_NUM) ? act_gate[IDX_W'(nxt_idx)] : '1;

endmodule

// File: rtl/gate_slot_scheduler.sv
// Time-aware gate scheduler: walks the gate control list against the cycle timer.
// Optional macro GATE_SHADOW_EN makes table writes take effect only at cycle boundaries.
module gate_slot_scheduler #(
  parameter int unsigned GATE_W    = tsn_sched_pkg::GATE_W,
  parameter int unsigned SLOT_NUM  = tsn_sched_pkg::SLOT_NUM,
  parameter int unsigned TIMER_MAX = tsn_sched_pkg::TIMER_MAX
) (
  input  logic                                       clk_sys,
  input  logic                                       reset_n,
  input  logic [tsn_sched_pkg::TIMER_W-1:0]          timer,
  input  logic                                       sync_pulse,
  output logic                                       timer_rst,
  input  logic                                       cfg_enable,
  input  logic [tsn_sched_pkg::SLOT_NUM_W-1:0]       cfg_slot_num,
  input  logic                                       cfg_wr,
  input  logic [tsn_sched_pkg::SLOT_W-1:0]           cfg_addr,
  input  logic [tsn_sched_pkg::TIMER_W+GATE_W-1:0]   cfg_wdata,
  output logic [GATE_W-1:0]                          gate_state,
  output logic [tsn_sched_pkg::SLOT_W-1:0]           slot_id
);
  import tsn_sched_pkg::*;

  sched_state_e       state;
  logic [SLOT_W-1:0]  last;
  logic               at_max;
  logic               advance;
  logic [TIMER_W-1:0] cur_end;
  logic [GATE_W-1:0]  nxt_gate;
  logic [GATE_W-1:0]  first_gate;

  assign last    = last_slot(cfg_slot_num, SLOT_NUM);
  assign at_max  = (timer == TIMER_W'(TIMER_MAX));
  // End values beyond TIMER_MAX can never be met, so such a slot holds until the wrap.
  assign advance = (timer >= cur_end) && (slot_id < last);

  gcl_table #(
    .GATE_W    (GATE_W),
    .SLOT_NUM  (SLOT_NUM),
    .TIMER_MAX (TIMER_MAX)
  ) u_gcl_table (
    .clk          (clk_sys),
    .rst_n        (reset_n),
    .wr           (cfg_wr),
    .addr         (cfg_addr),
    .wr_end       (cfg_wdata[TIMER_W+GATE_W-1:GATE_W]),
    .wr_gate      (cfg_wdata[GATE_W-1:0]),
`ifdef GATE_SHADOW_EN
    .commit       (at_max || sync_pulse),
`endif
    .cur_idx      (slot_id),
    .cur_end_c    (cur_end),
    .nxt_gate_c   (nxt_gate),
    .first_gate_c (first_gate)
  );

  // Schedule FSM; sync beats wrap, wrap beats slot advance.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gate_state <= '1;
      slot_id    <= '0;
      timer_rst  <= 1'b0;
    end else begin
      timer_rst <= sync_pulse;
      if (!cfg_enable) begin
        state      <= IDLE;
        gate_state <= '1;
        slot_id    <= '0;
      end else begin
        case (state)
          IDLE: begin
            gate_state <= '1;
            slot_id    <= '0;
            if (timer == '0) begin
              state      <= RUN;
              gate_state <= first_gate;
            end
          end
          RUN: begin
            if (sync_pulse || at_max) begin
              slot_id    <= '0;
              gate_state <= first_gate;
            end else if (advance) begin
              slot_id    <= slot_id + SLOT_W'(1);
              gate_state <= nxt_gate;
            end
          end
          default: begin
            state      <= IDLE;
            gate_state <= '1;
            slot_id    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_slot_scheduler.sv
// Directed bench for gate_slot_scheduler (TIMER_MAX=399, SLOT_NUM=8, GATE_W=8).
module tb_gate_slot_scheduler;

  localparam int unsigned TMAX = 399;
  localparam int unsigned GW   = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [18:0]   timer;
  logic          sync_pulse;
  logic          timer_rst;
  logic          cfg_enable;
  logic [4:0]    cfg_slot_num;
  logic          cfg_wr;
  logic [3:0]    cfg_addr;
  logic [26:0]   cfg_wdata;
  logic [GW-1:0] gate_state;
  logic [3:0]    slot_id;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  gate_slot_scheduler #(
    .GATE_W    (GW),
    .SLOT_NUM  (8),
    .TIMER_MAX (TMAX)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .timer        (timer),
    .sync_pulse   (sync_pulse),
    .timer_rst    (timer_rst),
    .cfg_enable   (cfg_enable),
    .cfg_slot_num (cfg_slot_num),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .gate_state   (gate_state),
    .slot_id      (slot_id)
  );

  // One clock; outputs are then stable and the external timer model steps.
  task automatic adv();
    @(posedge clk_sys);
    #1;
    if (timer_rst) timer = '0;
    else if (timer == 19'(TMAX)) timer = '0;
    else timer = timer + 19'd1;
  endtask

  task automatic run_to(input int t);
    int n;
    n = 0;
    while (int'(timer) != t) begin
      adv();
      n++;
      if (n > 2000) begin
        total++;
        bad++;
        $display("FAIL run_to timeout: timer=%0d wanted %0d", timer, t);
        break;
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input int e, input logic [7:0] g);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = {19'(e), g};
    adv();
    cfg_wr    = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] eg, input logic [3:0] es);
    total++;
    if (gate_state !== eg || slot_id !== es) begin
      bad++;
      $display("FAIL %s: gate=%h slot=%0d, expected gate=%h slot=%0d", name, gate_state, slot_id, eg, es);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; timer = 19'd5; sync_pulse = 1'b0; cfg_enable = 1'b0;
    cfg_slot_num = 5'd2; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    total++;
    if (gate_state !== 8'hFF || slot_id !== 4'd0 || timer_rst !== 1'b0) begin
      bad++;
      $display("FAIL reset: gate=%h slot=%0d trst=%b expected ff/0/0", gate_state, slot_id, timer_rst);
    end
    reset_n = 1'b1;
    // Reset table has end=TIMER_MAX everywhere: slot 0 never advances.
    cfg_enable = 1'b1;
    run_to(0);
    run_to(399);
    chk("reset_table_t399", 8'hFF, 4'd0);
    run_to(1);
    chk("reset_table_wrap", 8'hFF, 4'd0);
    cfg_enable = 1'b0;
    adv();
  endtask

  task automatic test_schedule();
    wr(4'd0, 99,  8'h01);
    wr(4'd1, 199, 8'h02);
    wr(4'd2, 399, 8'h80);
    cfg_slot_num = 5'd3;
    cfg_enable   = 1'b1;
    run_to(0);
    run_to(99);  chk("sched_t99",  8'h01, 4'd0);
    run_to(101); chk("sched_t101", 8'h02, 4'd1);
    run_to(199); chk("sched_t199", 8'h02, 4'd1);
    run_to(201); chk("sched_t201", 8'h80, 4'd2);
    run_to(399); chk("sched_t399", 8'h80, 4'd2);
    run_to(1);   chk("sched_wrap", 8'h01, 4'd0);
  endtask

  task automatic test_sync();
    run_to(150); chk("sync_pre", 8'h02, 4'd1);
    sync_pulse = 1'b1;
    adv();
    sync_pulse = 1'b0;
    chk("sync_slot", 8'h01, 4'd0);
    total++;
    if (timer_rst !== 1'b1) begin bad++; $display("FAIL sync_trst_on: got %b expected 1", timer_rst); end
    adv();
    total++;
    if (timer_rst !== 1'b0) begin bad++; $display("FAIL sync_trst_off: got %b expected 0", timer_rst); end
    // Sync coinciding with a slot advance wins.
    run_to(99);
    sync_pulse = 1'b1;
    adv();
    sync_pulse = 1'b0;
    chk("sync_vs_advance", 8'h01, 4'd0);
    total++;
    if (timer_rst !== 1'b1) begin bad++; $display("FAIL sync_prio_trst: got %b expected 1", timer_rst); end
  endtask

  task automatic test_disable();
    run_to(150);
    cfg_enable = 1'b0;
    adv();
    chk("disable", 8'hFF, 4'd0);
    cfg_enable = 1'b1;
    run_to(300); chk("reenable_wait", 8'hFF, 4'd0);
    run_to(0);   chk("reenable_t0", 8'hFF, 4'd0);
    adv();       chk("reenable_run", 8'h01, 4'd0);
  endtask

  task automatic test_slot_num0();
    cfg_slot_num = 5'd0;
    run_to(150); chk("num0_t150", 8'h01, 4'd0);
    run_to(399); chk("num0_t399", 8'h01, 4'd0);
    run_to(1);   chk("num0_wrap", 8'h01, 4'd0);
  endtask

  task automatic test_addr_ignore();
    wr(4'd2, 249, 8'h80);
    wr(4'd3, 259, 8'h08);
    wr(4'd4, 269, 8'h10);
    wr(4'd5, 279, 8'h20);
    wr(4'd6, 289, 8'h40);
    wr(4'd15, 50, 8'h33);
    cfg_slot_num = 5'd20;
    run_to(0);
    run_to(265); chk("clamp_t265", 8'h10, 4'd4);
    run_to(295); chk("addr15_slot7", 8'hFF, 4'd7);
  endtask

  task automatic test_same_cycle();
    cfg_slot_num = 5'd3;
    run_to(0);
    run_to(99);
    wr(4'd1, 199, 8'h77);
    chk("same_cycle_old", 8'h02, 4'd1);
    run_to(1);
    run_to(101); chk("same_cycle_new", 8'h77, 4'd1);
  endtask

  task automatic test_shadow();
    run_to(300);
    wr(4'd0, 99, 8'h55);
    run_to(350); chk("rewrite_hold", 8'h80, 4'd2);
    run_to(1);   chk("rewrite_wrap", 8'h55, 4'd0);
    run_to(50);
    wr(4'd1, 199, 8'h66);
    run_to(150);
`ifdef GATE_SHADOW_EN
    chk("midcycle_write", 8'h77, 4'd1);
`else
    chk("midcycle_write", 8'h66, 4'd1);
`endif
    run_to(1);
    run_to(150); chk("midcycle_next", 8'h66, 4'd1);
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_sync();
    test_disable();
    test_slot_num0();
    test_addr_ignore();
    test_same_cycle();
    test_shadow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
